// File: rtl/fifo_pkg.sv
// Shared helpers for the flex_fifo family: pointer wrap arithmetic and
// level-signal sizing that works for any depth, power of two or not.
package fifo_pkg;

    // Next pointer value, wrapping from depth-1 back to 0 without ever
    // visiting values >= depth.
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        if (ptr >= depth - 1)
            return 0;
        else
            return ptr + 1;
    endfunction

    // Width needed to represent a level in 0..depth inclusive.
    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dvr_if.sv
// Data/valid/ready stream bundle. The slave side receives data, the
// master side produces it.
interface dvr_if #(
    parameter int W = 8
) ();
    logic [W-1:0] data;
    logic         vld;
    logic         rdy;

    modport slave  (input data, input vld, output rdy);
    modport master (output data, output vld, input rdy);
endinterface

// File: rtl/flex_fifo_wrap_ctr.sv
// Modulo-DEPTH pointer with synchronous clear; clear wins over increment.
module wrap_ctr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clr,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Next pointer: clear, wrap-aware increment, or hold.
    always_comb begin
        ptr_d = ptr_q;
        if (clr)
            ptr_d = '0;
        else if (inc)
            ptr_d = PW'(wrap_inc(32'(ptr_q), DEPTH));
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr_q <= '0;
        else
            ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/flex_fifo.sv
// Single-clock first-word-fall-through FIFO with arbitrary depth,
// programmable almost-full/almost-empty flags, synchronous flush and a
// high-water-mark of the fill level. All status outputs derive from
// registered state, so neither write.vld nor read.rdy reaches an output
// combinationally.
module flex_fifo
    import fifo_pkg::*;
#(
    parameter int  DATA_WIDTH = 8,
    parameter int  FIFO_DEPTH = 4,
    localparam int LW         = level_w(FIFO_DEPTH),
    localparam int PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    dvr_if.slave          write,
    dvr_if.master         read,
    input  logic          flush,
    input  logic [LW-1:0] af_thresh,
    input  logic [LW-1:0] ae_thresh,
    output logic [LW-1:0] fill_level,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [LW-1:0] peak_level
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] count_q, count_d;
    logic [LW-1:0] peak_q, peak_d;
    logic          wr_en;
    logic          rd_en;

    assign full  = (count_q == LW'(FIFO_DEPTH));
    assign empty = (count_q == '0);

    // A handshake in the flush cycle is dropped entirely.
    assign wr_en = write.vld && !full  && !flush;
    assign rd_en = read.rdy  && !empty && !flush;

    assign write.rdy = !full;
    assign read.vld  = !empty;
    assign read.data = mem[rd_ptr];

    wrap_ctr #(.DEPTH(FIFO_DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wr_en),
        .clr   (flush),
        .ptr   (wr_ptr)
    );

    wrap_ctr #(.DEPTH(FIFO_DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rd_en),
        .clr   (flush),
        .ptr   (rd_ptr)
    );

    // Storage is write-only on accept and deliberately has no reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= write.data;
    end

    // Next fill count and peak; flush overrides both.
    always_comb begin
        count_d = count_q;
        peak_d  = peak_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
        if (count_d > peak_q)
            peak_d = count_d;
        if (flush) begin
            count_d = '0;
            peak_d  = '0;
        end
    end

    // Fill count and high-water-mark registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            peak_q  <= '0;
        end else begin
            count_q <= count_d;
            peak_q  <= peak_d;
        end
    end

    assign fill_level   = count_q;
    assign peak_level   = peak_q;
    assign almost_full  = (count_q >= af_thresh);
    assign almost_empty = (count_q <= ae_thresh);

endmodule

// File: tb/tb_flex_fifo.sv
module tb_flex_fifo;

    localparam int DW = 8;
    localparam int D  = 3;
    localparam int LW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic [LW-1:0] af_thresh;
    logic [LW-1:0] ae_thresh;
    logic [LW-1:0] fill_level;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [LW-1:0] peak_level;

    dvr_if #(.W(DW)) wr_if ();
    dvr_if #(.W(DW)) rd_if ();

    flex_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .write        (wr_if),
        .read         (rd_if),
        .flush        (flush),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .fill_level   (fill_level),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .peak_level   (peak_level)
    );

    always #5 clk = ~clk;

    int         vec_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: a read handshake is visible at the falling edge before the
    // rising edge that consumes it.
    always @(negedge clk) begin
        if (rst_n && !flush && rd_if.vld && rd_if.rdy) begin
            vec_cnt++;
            if (exp_q.size() == 0) begin
                err_cnt++;
                $display("FAIL read_data: got unexpected word 0x%02h, none expected", rd_if.data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rd_if.data !== e) begin
                    err_cnt++;
                    $display("FAIL read_data: got 0x%02h expected 0x%02h", rd_if.data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        wr_if.vld  = 1'b1;
        wr_if.data = d;
        tick();
        wr_if.vld  = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        af_thresh  = 2'd2;
        ae_thresh  = 2'd0;
        wr_if.vld  = 1'b1;
        wr_if.data = 8'h55;
        rd_if.rdy  = 1'b0;

        // Reset, with a write being offered
        repeat (3) tick();
        check("rst_wr_rdy", int'(wr_if.rdy), 1);
        check("rst_rd_vld", int'(rd_if.vld), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_fill", int'(fill_level), 0);
        check("rst_peak", int'(peak_level), 0);
        check("rst_ae", int'(almost_empty), 1);
        check("rst_af", int'(almost_full), 0);
        @(negedge clk);
        rst_n     = 1'b1;
        wr_if.vld = 1'b0;
        tick();
        check("rst_nothing_stored", int'(fill_level), 0);

        // Fill then drain
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        wr(8'h11);
        check("fill1_level", int'(fill_level), 1);
        check("fill1_rd_vld", int'(rd_if.vld), 1);
        wr(8'h22);
        wr(8'h33);
        check("fill_full", int'(full), 1);
        check("fill_wr_rdy", int'(wr_if.rdy), 0);
        check("fill_af", int'(almost_full), 1);
        check("fill_peak", int'(peak_level), 3);
        rd_if.rdy = 1'b1;
        repeat (3) tick();
        rd_if.rdy = 1'b0;
        check("drain_empty", int'(empty), 1);
        check("drain_peak", int'(peak_level), 3);
        check("drain_q", exp_q.size(), 0);

        // Continuous streaming across the non-power-of-two wrap
        for (int i = 0; i < 10; i++) exp_q.push_back(8'(i));
        wr_if.vld = 1'b1;
        rd_if.rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr_if.data = 8'(i);
            tick();
            check("stream_fill", int'(fill_level), 1);
        end
        wr_if.vld = 1'b0;
        tick();
        rd_if.rdy = 1'b0;
        check("stream_empty", int'(empty), 1);
        check("stream_q", exp_q.size(), 0);

        // Write and read both requested at full
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hA2);
        exp_q.push_back(8'hA3);
        wr(8'hA0);
        wr(8'hA1);
        wr(8'hA2);
        check("sim_full", int'(full), 1);
        wr_if.vld  = 1'b1;
        wr_if.data = 8'hA3;
        rd_if.rdy  = 1'b1;
        tick();
        check("sim_fill_read_only", int'(fill_level), 2);
        check("sim_full_release", int'(full), 0);
        check("sim_wr_rdy_release", int'(wr_if.rdy), 1);
        tick();
        check("sim_fill_both", int'(fill_level), 2);
        wr_if.vld = 1'b0;
        repeat (2) tick();
        rd_if.rdy = 1'b0;
        check("sim_empty", int'(empty), 1);
        check("sim_q", exp_q.size(), 0);

        // Flush with a concurrent write that must be dropped
        wr(8'hB1);
        wr(8'hB2);
        check("fl_pre_fill", int'(fill_level), 2);
        flush      = 1'b1;
        wr_if.vld  = 1'b1;
        wr_if.data = 8'hAA;
        tick();
        flush     = 1'b0;
        wr_if.vld = 1'b0;
        check("fl_fill", int'(fill_level), 0);
        check("fl_peak", int'(peak_level), 0);
        check("fl_empty", int'(empty), 1);
        check("fl_rd_vld", int'(rd_if.vld), 0);
        rd_if.rdy = 1'b1;
        repeat (2) tick();
        exp_q.push_back(8'h5C);
        wr(8'h5C);
        tick();
        rd_if.rdy = 1'b0;
        check("fl_after_q", exp_q.size(), 0);
        check("fl_after_peak", int'(peak_level), 1);

        // Threshold boundaries
        af_thresh = 2'd0;
        #1;
        check("thr_af0_empty", int'(almost_full), 1);
        af_thresh = 2'd1;
        ae_thresh = 2'd1;
        #1;
        check("thr_af_empty", int'(almost_full), 0);
        exp_q.push_back(8'hC1);
        exp_q.push_back(8'hC2);
        wr(8'hC1);
        check("thr_one_af", int'(almost_full), 1);
        check("thr_one_ae", int'(almost_empty), 1);
        wr(8'hC2);
        check("thr_two_ae", int'(almost_empty), 0);
        check("thr_two_af", int'(almost_full), 1);
        ae_thresh = 2'd3;
        wr(8'hC3);
        exp_q.push_back(8'hC3);
        check("thr_ae_max_at_full", int'(almost_empty), 1);
        rd_if.rdy = 1'b1;
        repeat (4) tick();
        rd_if.rdy = 1'b0;
        check("end_q", exp_q.size(), 0);
        check("end_empty", int'(empty), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
